// File: rtl/iter_shift_unit_if.sv
// Handshake bundle for iter_shift_unit: request side (in_*), result side (out_*)
// and the busy status. The slave modport is the shifter's view; master is the
// view of whoever drives requests and consumes results.
interface iter_shift_unit_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 6
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_sticky;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sticky, busy
  );

endinterface

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle dynamic shifter (SRL, SRA, SLL, ROR).
// A request is latched in IDLE, shifted by at most STEP bits per SHIFT cycle,
// and presented in DONE until the consumer takes it.
// Optional feature macro: ITER_SHIFT_STICKY_EN (accumulates the OR of all
// bits shifted out into out_sticky; without it out_sticky is constant 0).
// Reset is asynchronous and active-low.
module iter_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 6,
  parameter int STEP    = 4
) (
  input  logic             clock,
  input  logic             reset,
  iter_shift_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [31:0]      WIDTH_U = 32'(WIDTH);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] remaining_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;

  logic [31:0]      shamt_wide;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] step_amt;
  logic [WIDTH-1:0] shifted;

  // Effective amount: rotations wrap modulo WIDTH, plain shifts saturate at WIDTH
  always_comb begin
    shamt_wide = 32'(bus.in_shamt);
    if (bus.in_mode == MODE_ROR) begin
      eff = CNT_W'(shamt_wide % WIDTH_U);
    end else if (shamt_wide >= WIDTH_U) begin
      eff = WIDTH_C;
    end else begin
      eff = CNT_W'(shamt_wide);
    end
  end

  // One SHIFT step moves min(STEP, remaining) bits in the latched mode
  always_comb begin
    step_amt = (remaining_q > STEP_C) ? STEP_C : remaining_q;
    case (mode_q)
      MODE_SRL: shifted = data_q >> step_amt;
      MODE_SRA: shifted = $unsigned($signed(data_q) >>> step_amt);
      MODE_SLL: shifted = data_q << step_amt;
      default:  shifted = (data_q >> step_amt) | (data_q << (WIDTH_C - step_amt));
    endcase
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      data_q      <= '0;
      mode_q      <= MODE_SRL;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q      <= bus.in_data;
            mode_q      <= bus.in_mode;
            remaining_q <= eff;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            if (eff != '0) begin
              state <= SHIFT;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q      <= shifted;
          remaining_q <= remaining_q - step_amt;
          if (remaining_q == step_amt) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef ITER_SHIFT_STICKY_EN

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             sticky_q;
  logic             step_sticky;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] high_mask;

  // Bits leaving the word this step: low bits for right shifts, high bits for SLL
  always_comb begin
    low_mask  = ~(ONES << step_amt);
    high_mask = ~(ONES >> step_amt);
    case (mode_q)
      MODE_SRL: step_sticky = |(data_q & low_mask);
      MODE_SRA: step_sticky = |(data_q & low_mask);
      MODE_SLL: step_sticky = |(data_q & high_mask);
      default:  step_sticky = 1'b0;
    endcase
  end

  // Sticky accumulator: cleared on accept, ORed once per SHIFT step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sticky_q <= 1'b0;
    end else if (state == SHIFT) begin
      sticky_q <= sticky_q | step_sticky;
    end
  end

  assign bus.out_sticky = sticky_q;

`else

  assign bus.out_sticky = 1'b0;

`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (WIDTH=16, SHAMT_W=6, STEP=4).
// Latency is counted in cycles from the accepting edge to the first cycle
// with out_valid high. Sticky expectations follow ITER_SHIFT_STICKY_EN.
module tb_iter_shift_unit;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 6;
  localparam int STEP    = 4;

  localparam logic [1:0] SRL = 2'b00;
  localparam logic [1:0] SRA = 2'b01;
  localparam logic [1:0] SLL = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

`ifdef ITER_SHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  iter_shift_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  iter_shift_unit #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W),
    .STEP   (STEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Directed operation table: operand, amount, mode, result, latency, raw sticky
  logic [15:0] tv_data  [0:8] = '{16'h8001, 16'h8000, 16'h8000, 16'h0001, 16'h0012,
                                  16'h8F00, 16'h00FF, 16'h1234, 16'h00FF};
  logic [5:0]  tv_shamt [0:8] = '{6'd1, 6'd18, 6'd18, 6'd15, 6'd20, 6'd5, 6'd8, 6'd16, 6'd63};
  logic [1:0]  tv_mode  [0:8] = '{SRL, SRA, SRL, SLL, ROR, SRA, SLL, ROR, SLL};
  logic [15:0] tv_exp   [0:8] = '{16'h4000, 16'hFFFF, 16'h0000, 16'h8000, 16'h2001,
                                  16'hFC78, 16'hFF00, 16'h1234, 16'h0000};
  int          tv_lat   [0:8] = '{2, 5, 5, 5, 2, 3, 3, 1, 5};
  bit          tv_stk   [0:8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Issue one request from IDLE and wait (bounded) for out_valid
  task automatic run_op(input logic [15:0] d, input logic [5:0] s, input logic [1:0] m,
                        output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Take the pending result with a one-cycle out_ready pulse
  task automatic complete_op();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_mode = SRL;
    bus.out_ready = 1'b0;
    #12;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_out_data got %h want 0000", bus.out_data); end
    vectors++; if (bus.out_sticky !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sticky got %b want 0", bus.out_sticky); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_modes();
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(tv_data[i], tv_shamt[i], tv_mode[i], lat);
      vectors++; if (lat !== tv_lat[i]) begin miscompares++; $display("[TB] FAIL mode_latency[%0d] got %0d want %0d", i, lat, tv_lat[i]); end
      vectors++; if (bus.out_data !== tv_exp[i]) begin miscompares++; $display("[TB] FAIL mode_data[%0d] got %h want %h", i, bus.out_data, tv_exp[i]); end
      vectors++; if (bus.out_sticky !== (tv_stk[i] & STICKY_ON)) begin miscompares++; $display("[TB] FAIL mode_sticky[%0d] got %b want %b", i, bus.out_sticky, tv_stk[i] & STICKY_ON); end
      complete_op();
      vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mode_release[%0d] got valid %b ready %b want 0 1", i, bus.out_valid, bus.in_ready); end
    end
  endtask

  task automatic test_sticky();
    int lat;
    run_op(16'h0003, 6'd1, SRL, lat);
    vectors++; if (bus.out_data !== 16'h0001) begin miscompares++; $display("[TB] FAIL sticky_a_data got %h want 0001", bus.out_data); end
    vectors++; if (bus.out_sticky !== STICKY_ON) begin miscompares++; $display("[TB] FAIL sticky_a got %b want %b", bus.out_sticky, STICKY_ON); end
    complete_op();
    run_op(16'h0004, 6'd2, SRL, lat);
    vectors++; if (bus.out_data !== 16'h0001) begin miscompares++; $display("[TB] FAIL sticky_b_data got %h want 0001", bus.out_data); end
    vectors++; if (bus.out_sticky !== 1'b0) begin miscompares++; $display("[TB] FAIL sticky_b got %b want 0", bus.out_sticky); end
    complete_op();
  endtask

  task automatic test_stall();
    int lat;
    run_op(16'hA5C3, 6'd0, SRL, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL stall_latency got %0d want 1", lat); end
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h0F0F; bus.in_shamt = 6'd4; bus.in_mode = SLL;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, bus.out_valid); end
      vectors++; if (bus.out_data !== 16'hA5C3) begin miscompares++; $display("[TB] FAIL stall_data[%0d] got %h want a5c3", i, bus.out_data); end
      vectors++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_status[%0d] got ready %b busy %b want 0 1", i, bus.in_ready, bus.busy); end
    end
    complete_op();
    vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release got valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_no_queue got busy %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    run_op(16'h7FF0, 6'd3, SRA, lat);
    vectors++; if (lat !== 2 || bus.out_data !== 16'h0FFE) begin miscompares++; $display("[TB] FAIL b2b_first got lat %0d data %h want 2 0ffe", lat, bus.out_data); end
    @(posedge clock); #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_release got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
    run_op(16'h00F0, 6'd4, SRL, lat);
    vectors++; if (lat !== 2 || bus.out_data !== 16'h000F) begin miscompares++; $display("[TB] FAIL b2b_second got lat %0d data %h want 2 000f", lat, bus.out_data); end
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    bus.in_valid = 1'b1; bus.in_data = 16'h0001; bus.in_shamt = 6'd15; bus.in_mode = SLL;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_busy_before got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_async got valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_ready got %b want 1", bus.in_ready); end
    run_op(16'h00F0, 6'd6, SLL, lat);
    vectors++; if (lat !== 3 || bus.out_data !== 16'h3C00) begin miscompares++; $display("[TB] FAIL midrst_next got lat %0d data %h want 3 3c00", lat, bus.out_data); end
    complete_op();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_modes();
    test_sticky();
    test_stall();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
